// File: rtl/btn_debounce.sv
// Per-bit push-button conditioner: two-flop synchroniser, counter-based bounce filter,
// and registered one-cycle rise/fall pulses. All bits are fully independent.
module btn_debounce #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 50000,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_btn_in,
  output logic [WIDTH-1:0] o_btn_out,
  output logic [WIDTH-1:0] o_btn_rise,
  output logic [WIDTH-1:0] o_btn_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_btn_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  // NOTE: non-blocking assignments everywhere here, so every read of r_sync2, r_cnt and
  // r_btn_out below sees the value from before this edge regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_btn_out <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      // NOTE: the counter array must be cleared explicitly; a pending count surviving
      // reset would let a pre-reset edge reach the output early.
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (r_sync2[i] == r_btn_out[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          // Level held for CNT_MAX consecutive edges: accept it and flag the direction.
          r_btn_out[i] <= r_sync2[i];
          r_rise[i]    <= r_sync2[i];
          r_fall[i]    <= ~r_sync2[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_btn_out  = r_btn_out;
  assign o_btn_rise = r_rise;
  assign o_btn_fall = r_fall;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (WIDTH=2, CNT_MAX=4): directed vector table,
// multi-cycle corner sequences, and random stimulus against a sliding-window model.
module tb_btn_debounce;

  localparam int WIDTH   = 2;
  localparam int CNT_MAX = 4;

  logic             clk = 1'b0;
  logic             i_rst;
  logic [WIDTH-1:0] i_btn_in;
  logic [WIDTH-1:0] o_btn_out;
  logic [WIDTH-1:0] o_btn_rise;
  logic [WIDTH-1:0] o_btn_fall;

  btn_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .CNT_W(16)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_btn_in  (i_btn_in),
    .o_btn_out (o_btn_out),
    .o_btn_rise(o_btn_rise),
    .o_btn_fall(o_btn_fall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: input reaches the filter two edges late; a bit flips once the
  // last CNT_MAX filter samples all disagree with the current output.
  logic [WIDTH-1:0] m_out, m_rise, m_fall;
  logic [WIDTH-1:0] m_dly [$];
  logic [WIDTH-1:0] m_win [$];

  task automatic model_edge(input logic rst, input logic [WIDTH-1:0] btn);
    logic [WIDTH-1:0] s2;
    if (rst) begin
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
      m_dly.delete();
      m_dly.push_back('0);
      m_dly.push_back('0);
      m_win.delete();
      repeat (CNT_MAX) m_win.push_back('0);
      return;
    end
    s2 = m_dly.pop_front();
    m_dly.push_back(btn);
    void'(m_win.pop_front());
    m_win.push_back(s2);
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < WIDTH; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      foreach (m_win[k]) if (m_win[k][b] == m_out[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_out[b]  = s2[b];
        m_rise[b] = s2[b];
        m_fall[b] = ~s2[b];
      end
    end
  endtask

  task automatic step(input logic rst, input logic [WIDTH-1:0] btn);
    i_rst    = rst;
    i_btn_in = btn;
    @(posedge clk);
    model_edge(rst, btn);
    #1;
    check("model out",  o_btn_out,  m_out);
    check("model rise", o_btn_rise, m_rise);
    check("model fall", o_btn_fall, m_fall);
  endtask

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] btn;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input logic rst, input logic [WIDTH-1:0] btn, out, rise, fall,
                              input int n);
    vec_t v;
    v.rst  = rst;
    v.btn  = btn;
    v.out  = out;
    v.rise = rise;
    v.fall = fall;
    repeat (n) vecs.push_back(v);
  endfunction

  initial begin
    int edges;
    logic [WIDTH-1:0] btn;

    i_rst    = 1'b1;
    i_btn_in = '0;

    // Reset with both pins high, then accept 11.
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 3);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
    add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2);
    // Release bit 1.
    add(0, 2'b01, 2'b11, 2'b00, 2'b00, 5);
    add(0, 2'b01, 2'b01, 2'b00, 2'b10, 1);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2);
    // Opposite edges on both bits together, in each direction.
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 5);
    add(0, 2'b10, 2'b10, 2'b10, 2'b01, 1);
    add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2);
    add(0, 2'b01, 2'b10, 2'b00, 2'b00, 5);
    add(0, 2'b01, 2'b01, 2'b01, 2'b10, 1);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2);
    // Clean press on bit 0 from a fresh reset.
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 3);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn);
      check($sformatf("vec%0d out", i),  o_btn_out,  vecs[i].out);
      check($sformatf("vec%0d rise", i), o_btn_rise, vecs[i].rise);
      check($sformatf("vec%0d fall", i), o_btn_fall, vecs[i].fall);
    end

    // Bounce: 1,0,1,0 for two edges each, then settle high.
    repeat (2) step(1, 2'b00);
    for (int t = 0; t < 8; t++) begin
      step(0, (t % 4 < 2) ? 2'b01 : 2'b00);
      check("bounce hold", o_btn_out, 2'b00);
    end
    edges = 0;
    for (int t = 1; t <= 20 && edges == 0; t++) begin
      step(0, 2'b01);
      if (o_btn_rise[0]) edges = t;
    end
    check("bounce settle edges", edges, CNT_MAX + 2);
    check("bounce out", o_btn_out, 2'b01);

    // Reset in the middle of a pending count.
    repeat (2) step(1, 2'b00);
    repeat (3) step(0, 2'b01);
    step(1, 2'b01);
    check("midrst out", o_btn_out, 2'b00);
    check("midrst rise", o_btn_rise, 2'b00);
    for (int t = 1; t <= 5; t++) begin
      step(0, 2'b01);
      check("midrst wait", o_btn_out, 2'b00);
    end
    step(0, 2'b01);
    check("midrst rise6", o_btn_rise, 2'b01);
    check("midrst out6", o_btn_out, 2'b01);

    // Three-edge glitches on each bit never reach the output.
    repeat (2) step(1, 2'b00);
    for (int b = 0; b < WIDTH; b++) begin
      btn = '0;
      btn[b] = 1'b1;
      repeat (3) step(0, btn);
      for (int t = 0; t < 8; t++) begin
        step(0, 2'b00);
        check($sformatf("glitch%0d out", b), o_btn_out, 2'b00);
        check($sformatf("glitch%0d rise", b), o_btn_rise, 2'b00);
      end
    end

    // Randomised stimulus against the model.
    btn = '0;
    for (int t = 0; t < 4000; t++) begin
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, 3) == 0) btn[b] = ~btn[b];
      step($urandom_range(0, 299) == 0, btn);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
